// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results and aligned/extended load data to the register file.
// Optional load-response timeout with sticky ld_err is enabled by defining WB_LD_TIMEOUT_EN.
module wb_stage #(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic [1:0]      ex_ld_size,
    input  logic            ex_ld_unsigned,
    input  logic [1:0]      ex_addr_lo,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_data,
    output logic            rf_we,
    output logic [4:0]      rf_adr_wrt,
    output logic [XLEN-1:0] rf_data_in,
    output logic            byp_pending,
    output logic [4:0]      byp_rd,
    output logic            ld_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    // Elaboration guard: only a 32-bit datapath and an 8-bit-countable timeout are supported.
    if (XLEN != 32 || RSP_TIMEOUT < 1 || RSP_TIMEOUT > 256) begin : g_param_check
        $error("wb_stage: unsupported XLEN or RSP_TIMEOUT");
    end

    // Select the addressed lane of the load word, then sign- or zero-extend it.
    function automatic logic [31:0] ld_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t            state_r;
    logic [4:0]        ld_rd_r;
    logic [1:0]        ld_size_r;
    logic              ld_uns_r;
    logic [1:0]        ld_lo_r;
    logic              rf_we_r;
    logic [4:0]        rf_adr_wrt_r;
    logic [XLEN-1:0]   rf_data_in_r;
    logic              byp_pending_r;
    logic [4:0]        byp_rd_r;
    logic              xfer_s;
    logic [XLEN-1:0]   ld_data_s;

`ifdef WB_LD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(RSP_TIMEOUT - 1);
    logic [7:0]        cnt_r;
    logic              ld_err_r;
    assign ld_err = ld_err_r;
`else
    assign ld_err = 1'b0;
`endif

    assign ex_ready  = (state_r == IDLE);
    assign xfer_s    = ex_valid & ex_ready;
    assign ld_data_s = ld_extend(dmem_rsp_data, ld_size_r, ld_uns_r, ld_lo_r);

    assign rf_we       = rf_we_r;
    assign rf_adr_wrt  = rf_adr_wrt_r;
    assign rf_data_in  = rf_data_in_r;
    assign byp_pending = byp_pending_r;
    assign byp_rd      = byp_rd_r;

    // Writeback FSM with registered register-file write port and bypass info.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            ld_rd_r       <= 5'd0;
            ld_size_r     <= 2'b00;
            ld_uns_r      <= 1'b0;
            ld_lo_r       <= 2'b00;
            rf_we_r       <= 1'b0;
            rf_adr_wrt_r  <= 5'd0;
            rf_data_in_r  <= {XLEN{1'b0}};
            byp_pending_r <= 1'b0;
            byp_rd_r      <= 5'd0;
`ifdef WB_LD_TIMEOUT_EN
            cnt_r         <= 8'd0;
            ld_err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && ex_is_load) begin
                        state_r       <= WAIT_RSP;
                        ld_rd_r       <= ex_rd;
                        ld_size_r     <= ex_ld_size;
                        ld_uns_r      <= ex_ld_unsigned;
                        ld_lo_r       <= ex_addr_lo;
                        rf_we_r       <= 1'b0;
                        byp_pending_r <= (ex_rd != 5'd0);
                        // x0 loads never become visible to the bypass network.
                        if (ex_rd != 5'd0) begin
                            byp_rd_r <= ex_rd;
                        end else begin
                            byp_rd_r <= byp_rd_r;
                        end
`ifdef WB_LD_TIMEOUT_EN
                        cnt_r         <= 8'd0;
`endif
                    end else if (xfer_s) begin
                        rf_we_r <= (ex_rd != 5'd0);
                        if (ex_rd != 5'd0) begin
                            rf_adr_wrt_r <= ex_rd;
                            rf_data_in_r <= ex_result;
                            byp_rd_r     <= ex_rd;
                        end else begin
                            rf_adr_wrt_r <= rf_adr_wrt_r;
                            rf_data_in_r <= rf_data_in_r;
                            byp_rd_r     <= byp_rd_r;
                        end
                    end else begin
                        rf_we_r <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state_r       <= IDLE;
                        rf_we_r       <= (ld_rd_r != 5'd0);
                        byp_pending_r <= 1'b0;
                        if (ld_rd_r != 5'd0) begin
                            rf_adr_wrt_r <= ld_rd_r;
                            rf_data_in_r <= ld_data_s;
                            byp_rd_r     <= ld_rd_r;
                        end else begin
                            rf_adr_wrt_r <= rf_adr_wrt_r;
                            rf_data_in_r <= rf_data_in_r;
                            byp_rd_r     <= byp_rd_r;
                        end
                    end
`ifdef WB_LD_TIMEOUT_EN
                    // A response on the final wait cycle takes priority over the timeout.
                    else if (cnt_r == TIMEOUT_LAST) begin
                        state_r       <= IDLE;
                        rf_we_r       <= 1'b0;
                        byp_pending_r <= 1'b0;
                        ld_err_r      <= 1'b1;
                    end
`endif
                    else begin
                        rf_we_r <= 1'b0;
`ifdef WB_LD_TIMEOUT_EN
                        cnt_r   <= cnt_r + 8'd1;
`endif
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    rf_we_r       <= 1'b0;
                    byp_pending_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the CPU pipeline. It sits directly upstream of the register file and drives its write port (we, adr_wrt, data_in).
- Accepts completed results from execute over a valid/ready handshake. For loads, it waits for the data-memory response, then aligns and extends the data before the write.
- Also publishes forwarding/hazard information to the operand-fetch logic.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RSP_TIMEOUT, 255, max cycles to wait for a load response. Used only with WB_LD_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- ex_valid  in  1  execute presents a result.
- ex_ready  out  1  stage can accept this cycle.
- ex_rd  in  5  destination register.
- ex_result  in  32  ALU result; ignored for loads.
- ex_is_load  in  1  instruction is a load.
- ex_ld_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- ex_ld_unsigned  in  1  zero-extend instead of sign-extend.
- ex_addr_lo  in  2  load address bits [1:0].
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_data  in  32  load word from memory.
- rf_we  out  1  register-file write enable.
- rf_adr_wrt  out  5  register-file write address.
- rf_data_in  out  32  register-file write data.
- byp_pending  out  1  load outstanding; consumers of byp_rd must stall.
- byp_rd  out  5  rd of the outstanding load or of the current write.
- ld_err  out  1  timeout sticky flag (feature only; tied 0 otherwise).

Behaviour:
- Reset values (while reset=0, asynchronously):
  - state=IDLE.
  - rf_we=0, rf_adr_wrt=0, rf_data_in=0.
  - byp_pending=0, byp_rd=0, ld_err=0.
  - The pending load context is discarded.
- States: IDLE, WAIT_RSP.
- ex_ready=1 only in IDLE (combinational from state). A transfer occurs when ex_valid && ex_ready.
- IDLE, transfer, non-load:
  - Next cycle: rf_we=1, rf_adr_wrt=ex_rd, rf_data_in=ex_result. Latency is 1 cycle.
  - Back-to-back transfers sustain one write per cycle.
- IDLE, transfer, load:
  - Latch rd, size, unsigned and addr_lo; go to WAIT_RSP. rf_we=0 next cycle.
  - byp_pending=1 and byp_rd=latched rd from the next cycle until the write cycle.
- WAIT_RSP, dmem_rsp_valid=1:
  - Next cycle: rf_we=1 with the extended data; state returns to IDLE.
  - A response in the same cycle as the load transfer is not sampled. The earliest usable response is the cycle after the transfer.
- WAIT_RSP, dmem_rsp_valid=0: hold state, rf_we=0.
- dmem_rsp_valid in IDLE is ignored.
- rf_we is a single-cycle pulse per committed instruction. Outputs hold their last value when rf_we=0; only rf_we is meaningful.
- Whenever rf_we=1, byp_rd equals rf_adr_wrt (forwarding of the in-flight write).
- rd=0: the handshake completes and a load still waits for its response, but rf_we stays 0 and byp_pending stays 0.
- Load extension (byte lane chosen from the latched addr_lo):
  - Byte: lane = addr_lo (0 selects [7:0], 3 selects [31:24]).
  - Half: lane = addr_lo[1] (0 selects [15:0], 1 selects [31:16]); addr_lo[0] is ignored.
  - Word: full 32 bits; addr_lo is ignored.
  - Sign-extend from the lane MSB unless unsigned=1, in which case zero-fill.
- Reset asserted mid-load drops the load silently. No write occurs after reset release.

Optional Feature:
- Macro WB_LD_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on load transfer and increments each WAIT_RSP cycle.
  - When the counter reaches RSP_TIMEOUT with no response, the stage returns to IDLE without a write, clears byp_pending, and sets ld_err=1.
  - ld_err is sticky until reset.
  - A response arriving on the timeout cycle wins: it is written and no error is flagged.
- Undefined: no counter; WAIT_RSP waits indefinitely; ld_err is tied 0.

Test Plan:
- ALU stream: 3 consecutive transfers (rd=1/2/3, result=0x11/0x22/0x33) → rf_we=1 on 3 consecutive cycles, each one cycle after its transfer, with matching address/data; ex_ready stays 1.
- Signed byte load: rd=5, size=00, unsigned=0, addr_lo=3; rsp 0x80FF_0000 two cycles later → ex_ready=0 and byp_pending=1 (byp_rd=5) while waiting; write rd=5, data=0xFFFF_FF80, then ex_ready=1.
- Unsigned half load: addr_lo=2, rsp 0x8001_1234 → data 0x0000_8001. Same with unsigned=0 → 0xFFFF_8001. Word load, addr_lo=1, rsp 0xCAFE_BABE → 0xCAFE_BABE.
- rd=0: ALU op with result 0x5 → no rf_we. Load to rd=0 → ex_ready low until the response, byp_pending stays 0, no write.
- Reset mid-op: drive reset=0 asynchronously during WAIT_RSP → all outputs go to 0 immediately. After release, a late dmem_rsp_valid causes no write.
- WB_LD_TIMEOUT_EN with RSP_TIMEOUT=4: load with no response → return to IDLE after 4 wait cycles, no write, ld_err=1 and held. A response exactly on cycle 4 → written, ld_err=0.
